l1_mem_arbiter: RTL and testbench

Two-master arbiter between the L1 instruction cache and L1 data cache memory-side ports and the single memory generic bus. Each cache's `mem_gen_bus_if` (cpu modport) connects to one requester port. The arbiter grants the memory bus to one cache at a time and holds the grant across a cache's FETCH/WB burst. It can preempt a long burst on a beat boundary so the other cache is not starved.

---
 rtl/l1_mem_arbiter_if.sv | 21 ++
 rtl/l1_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_l1_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_mem_arbiter_if.sv
// Generic memory bus shared by the L1 caches and the memory port.
// The cpu side drives requests and the generic_bus side answers with rdata/busy.
interface generic_bus_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ren;
  logic        wen;
  logic        busy;
  logic [3:0]  byte_en;

  modport cpu (
    output addr, wdata, ren, wen, byte_en,
    input  rdata, busy
  );

  modport generic_bus (
    input  addr, wdata, ren, wen, byte_en,
    output rdata, busy
  );
endinterface

// File: rtl/l1_mem_arbiter.sv
// Two-master arbiter (I-cache, D-cache) onto one memory bus, with burst preemption after MAX_BEATS.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise D-cache has fixed priority.
module l1_mem_arbiter #(
  parameter int unsigned MAX_BEATS = 8
) (
  input  logic                    CLK,
  input  logic                    nRST,
  generic_bus_if.generic_bus      icache_bus,
  generic_bus_if.generic_bus      dcache_bus,
  generic_bus_if.cpu              mem_bus
);

  localparam int unsigned CNT_W = (MAX_BEATS == 0) ? 1 : $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_e;

  typedef enum logic {
    SEL_I = 1'b0,
    SEL_D = 1'b1
  } sel_e;

  state_e           state_q, state_d;
  sel_e             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic i_req, d_req;
  logic own_req, other_req;
  logic beat_done, quota_hit, tie_to_d;

  assign i_req = icache_bus.ren | icache_bus.wen;
  assign d_req = dcache_bus.ren | dcache_bus.wen;

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_to_d = (last_grant_q == SEL_I);
`else
  assign tie_to_d = 1'b1;
`endif

  // Preemption is allowed once the beat completing now reaches the quota.
  assign quota_hit = (MAX_BEATS != 0) &&
                     ((32'(beat_cnt_q) + 32'd1) >= MAX_BEATS);

  // NOTE: every variable written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin : next_state
    state_d      = state_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    own_req      = 1'b0;
    other_req    = 1'b0;

    case (state_q)
      GRANT_I: begin
        own_req   = i_req;
        other_req = d_req;
      end
      GRANT_D: begin
        own_req   = d_req;
        other_req = i_req;
      end
      default: ;
    endcase

    beat_done = own_req & ~mem_bus.busy;

    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          state_d = tie_to_d ? GRANT_D : GRANT_I;
        end else if (d_req) begin
          state_d = GRANT_D;
        end else if (i_req) begin
          state_d = GRANT_I;
        end
      end
      GRANT_I: begin
        if (!own_req) begin
          state_d = other_req ? GRANT_D : IDLE;
        end else if (beat_done && quota_hit && other_req) begin
          state_d = GRANT_D;
        end
      end
      GRANT_D: begin
        if (!own_req) begin
          state_d = other_req ? GRANT_I : IDLE;
        end else if (beat_done && quota_hit && other_req) begin
          state_d = GRANT_I;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new owner starts a fresh beat count; dropping to IDLE keeps last_grant.
    if (state_d != state_q) begin
      beat_cnt_d = '0;
      if (state_d == GRANT_I) begin
        last_grant_d = SEL_I;
      end else if (state_d == GRANT_D) begin
        last_grant_d = SEL_D;
      end
    end else if (beat_done && (beat_cnt_q != CNT_MAX)) begin
      beat_cnt_d = beat_cnt_q + CNT_ONE;
    end
  end

  always_comb begin : bus_mux
    mem_bus.addr      = '0;
    mem_bus.wdata     = '0;
    mem_bus.ren       = 1'b0;
    mem_bus.wen       = 1'b0;
    mem_bus.byte_en   = '0;
    icache_bus.rdata  = '0;
    icache_bus.busy   = 1'b1;
    dcache_bus.rdata  = '0;
    dcache_bus.busy   = 1'b1;

    // Only the registered owner reaches memory, so the other side cannot glitch it.
    case (state_q)
      GRANT_I: begin
        mem_bus.addr     = icache_bus.addr;
        mem_bus.wdata    = icache_bus.wdata;
        mem_bus.ren      = icache_bus.ren;
        mem_bus.wen      = icache_bus.wen;
        mem_bus.byte_en  = icache_bus.byte_en;
        icache_bus.rdata = mem_bus.rdata;
        icache_bus.busy  = mem_bus.busy;
      end
      GRANT_D: begin
        mem_bus.addr     = dcache_bus.addr;
        mem_bus.wdata    = dcache_bus.wdata;
        mem_bus.ren      = dcache_bus.ren;
        mem_bus.wen      = dcache_bus.wen;
        mem_bus.byte_en  = dcache_bus.byte_en;
        dcache_bus.rdata = mem_bus.rdata;
        dcache_bus.busy  = mem_bus.busy;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      last_grant_q <= SEL_I;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Self-checking bench: three arbiters (MAX_BEATS 2, 0, 8) share requester stimulus;
// a cycle-level reference model checks every output, plus directed scenario checks.
module tb_l1_mem_arbiter;

  function automatic int mb_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 0 : 8;
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic        i_ren, i_wen, d_ren, d_wen, mem_busy;
  logic [3:0]  i_be, d_be;

  logic [69:0] o_mem [3];
  logic [32:0] o_i   [3];
  logic [32:0] o_d   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    generic_bus_if i_if ();
    generic_bus_if d_if ();
    generic_bus_if m_if ();

    assign i_if.addr    = i_addr;
    assign i_if.wdata   = i_wdata;
    assign i_if.ren     = i_ren;
    assign i_if.wen     = i_wen;
    assign i_if.byte_en = i_be;
    assign d_if.addr    = d_addr;
    assign d_if.wdata   = d_wdata;
    assign d_if.ren     = d_ren;
    assign d_if.wen     = d_wen;
    assign d_if.byte_en = d_be;
    assign m_if.rdata   = {16'hAAAA, 8'h00, m_if.addr[7:0]};
    assign m_if.busy    = mem_busy;

    l1_mem_arbiter #(.MAX_BEATS(mb_of(g))) u_dut (
      .CLK        (clk),
      .nRST       (rst_n),
      .icache_bus (i_if),
      .dcache_bus (d_if),
      .mem_bus    (m_if)
    );

    assign o_mem[g] = {m_if.addr, m_if.wdata, m_if.ren, m_if.wen, m_if.byte_en};
    assign o_i[g]   = {i_if.rdata, i_if.busy};
    assign o_d[g]   = {d_if.rdata, d_if.busy};
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: owner 0 = nobody, 1 = I, 2 = D.
  int m_own [3];
  int m_cnt [3];
  int m_last[3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [69:0] em;
      logic [32:0] ei, ed, er;
      logic        req_i, req_d, mine, oth, beat;
      int          ns;
      if (!rst_n) begin
        m_own[k] = 0; m_cnt[k] = 0; m_last[k] = 1;
      end
      req_i = i_ren | i_wen;
      req_d = d_ren | d_wen;
      if (m_own[k] == 1)      em = {i_addr, i_wdata, i_ren, i_wen, i_be};
      else if (m_own[k] == 2) em = {d_addr, d_wdata, d_ren, d_wen, d_be};
      else                    em = '0;
      er = {16'hAAAA, 8'h00, em[45:38], mem_busy};
      ei = (m_own[k] == 1) ? er : {32'h0, 1'b1};
      ed = (m_own[k] == 2) ? er : {32'h0, 1'b1};
      check($sformatf("dut%0d_mem", k), o_mem[k], em);
      check($sformatf("dut%0d_icache", k), 70'(o_i[k]), 70'(ei));
      check($sformatf("dut%0d_dcache", k), 70'(o_d[k]), 70'(ed));
      if (rst_n) begin
        beat = 1'b0;
        if (m_own[k] == 0) begin
`ifdef ARB_ROUND_ROBIN_EN
          if (req_i && req_d) ns = (m_last[k] == 1) ? 2 : 1;
`else
          if (req_i && req_d) ns = 2;
`endif
          else if (req_d) ns = 2;
          else if (req_i) ns = 1;
          else ns = 0;
        end else begin
          mine = (m_own[k] == 1) ? req_i : req_d;
          oth  = (m_own[k] == 1) ? req_d : req_i;
          beat = mine && !mem_busy;
          if (!mine) ns = oth ? 3 - m_own[k] : 0;
          else if (beat && mb_of(k) != 0 && m_cnt[k] + 1 >= mb_of(k) && oth) ns = 3 - m_own[k];
          else ns = m_own[k];
        end
        if (ns != m_own[k]) begin
          m_cnt[k] = 0;
          if (ns != 0) m_last[k] = ns;
          m_own[k] = ns;
        end else if (beat) begin
          m_cnt[k]++;
        end
      end
    end
  end

  // Burst engines: each requester walks addr/wdata forward per completed beat.
  int          i_left = 0, d_left = 0, watch = 0;
  logic        i_done = 1'b0, d_done = 1'b0, log_en = 1'b0;
  logic [63:0] beat_log[$];

  task automatic start_i(input int n, input logic [31:0] a, input logic wr, input logic [31:0] wd);
    i_left = n; i_addr = a; i_wdata = wd; i_ren = !wr; i_wen = wr; i_be = 4'hF;
  endtask

  task automatic start_d(input int n, input logic [31:0] a, input logic wr, input logic [31:0] wd);
    d_left = n; d_addr = a; d_wdata = wd; d_ren = !wr; d_wen = wr; d_be = 4'hF;
  endtask

  task automatic stop_all();
    i_left = 0; d_left = 0;
    i_ren = 1'b0; i_wen = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (i_done && i_left > 0) begin
      i_addr += 4; i_wdata += 1; i_left--;
      if (i_left == 0) begin i_ren = 1'b0; i_wen = 1'b0; end
    end
    if (d_done && d_left > 0) begin
      d_addr += 4; d_wdata += 1; d_left--;
      if (d_left == 0) begin d_ren = 1'b0; d_wen = 1'b0; end
    end
  endtask

  task automatic smp();
    @(negedge clk);
    i_done = (i_ren | i_wen) && !o_i[watch][0];
    d_done = (d_ren | d_wen) && !o_d[watch][0];
    if (log_en && (o_mem[watch][5] | o_mem[watch][4]) && !mem_busy)
      beat_log.push_back({o_mem[watch][69:38], o_mem[watch][37:6]});
  endtask

  task automatic run_until_quiet(input string tag);
    bit quiet = 1'b0;
    for (int c = 0; c < 60 && !quiet; c++) begin
      tick();
      smp();
      if (watch == 0 && o_mem[0][5]) check({tag, "_d_held"}, 70'(o_d[0][0]), 70'd1);
      quiet = (i_left == 0) && (d_left == 0);
    end
    check({tag, "_timeout"}, 70'(quiet), 70'd1);
    tick(); smp();
  endtask

  task automatic check_log(input string tag, input logic [63:0] exp[$]);
    check({tag, "_len"}, 70'(beat_log.size()), 70'(exp.size()));
    for (int k = 0; k < exp.size(); k++)
      if (k < beat_log.size()) check($sformatf("%s_beat%0d", tag, k), 70'(beat_log[k]), 70'(exp[k]));
  endtask

  initial begin
    logic [31:0] tie_exp [3];
    logic [63:0] exp_q[$];
`ifdef ARB_ROUND_ROBIN_EN
    tie_exp = '{32'h2000, 32'h1000, 32'h2000};
`else
    tie_exp = '{32'h2000, 32'h2000, 32'h2000};
`endif
    rst_n = 1'b0; mem_busy = 1'b1;
    i_addr = '0; i_wdata = '0; d_addr = '0; d_wdata = '0; i_be = '0; d_be = '0;
    stop_all();
    #12 rst_n = 1'b1;

    // Tie from IDLE right after reset: D first, then I with no bubble.
    tick(); start_i(1, 32'h1000, 1'b0, 32'h0); start_d(1, 32'h2000, 1'b1, 32'h5A5A0000); mem_busy = 1'b0;
    smp(); check("t2_idle", 70'(o_mem[0][5:4]), 70'd0);
    tick(); smp(); check("t2_d_first", 70'({o_mem[0][69:38], o_mem[0][4]}), 70'({32'h2000, 1'b1}));
    tick(); smp(); check("t2_i_wait", 70'(o_i[0][0]), 70'd1);
    tick(); smp(); check("t2_i_next", 70'({o_mem[0][69:38], o_mem[0][5]}), 70'({32'h1000, 1'b1}));
    tick(); smp(); tick(); smp();

    // I-only two-beat read, memory busy two cycles per beat.
    tick(); start_i(2, 32'h100, 1'b0, 32'h0); mem_busy = 1'b1;
    smp(); check("t1_wait", 70'({o_mem[0][5], o_i[0][0]}), 70'({1'b0, 1'b1}));
    for (int b = 0; b < 2; b++) begin
      tick(); mem_busy = 1'b1; smp();
      check($sformatf("t1_addr%0d", b), 70'({o_mem[0][69:38], o_mem[0][5]}), 70'({32'h100 + 32'(4 * b), 1'b1}));
      tick(); mem_busy = 1'b1; smp();
      check($sformatf("t1_busy%0d", b), 70'(o_i[0][0]), 70'd1);
      tick(); mem_busy = 1'b0; smp();
      check($sformatf("t1_rdata%0d", b), 70'(o_i[0]), 70'({32'hAAAA0000 + 32'(4 * b), 1'b0}));
      check($sformatf("t1_d_busy%0d", b), 70'(o_d[0][0]), 70'd1);
    end
    tick(); mem_busy = 1'b1; smp(); tick(); smp();

    // Three ties released together: round-robin alternates, fixed priority keeps D.
    for (int t = 0; t < 3; t++) begin
      tick(); start_i(100, 32'h1000, 1'b0, 32'h0); start_d(100, 32'h2000, 1'b1, 32'h0); mem_busy = 1'b1;
      smp();
      tick(); smp();
      check($sformatf("t3_tie%0d", t), 70'(o_mem[0][69:38]), 70'(tie_exp[t]));
      tick(); stop_all(); smp();
      tick(); smp();
    end

    // MAX_BEATS=2 (dut0): D write burst preempted after 0x204 by a one-beat I read.
    watch = 0; beat_log.delete();
    tick(); mem_busy = 1'b0; start_d(4, 32'h200, 1'b1, 32'hD0000000); log_en = 1'b1; smp();
    tick(); start_i(1, 32'h100, 1'b0, 32'h0); smp();
    run_until_quiet("t4");
    log_en = 1'b0;
    exp_q = '{{32'h200, 32'hD0000000}, {32'h204, 32'hD0000001}, {32'h100, 32'h0},
              {32'h208, 32'hD0000002}, {32'h20C, 32'hD0000003}};
    check_log("t4", exp_q);

    // MAX_BEATS=0 (dut1): eight-beat D burst is never preempted.
    watch = 1; beat_log.delete();
    tick(); start_d(8, 32'h300, 1'b1, 32'hD1000000); log_en = 1'b1; smp();
    tick(); start_i(1, 32'h140, 1'b0, 32'h0); smp();
    run_until_quiet("t5");
    log_en = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back({32'h300 + 32'(4 * k), 32'hD1000000 + 32'(k)});
    exp_q.push_back({32'h140, 32'h0});
    check_log("t5", exp_q);
    watch = 0;

    // Asynchronous reset in the middle of an I beat.
    tick(); start_i(4, 32'h180, 1'b0, 32'h0); mem_busy = 1'b1; smp();
    tick(); smp(); check("t6_granted", 70'(o_mem[0][5]), 70'd1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 check("t6_rst_mem", o_mem[0], 70'd0);
    check("t6_rst_busy", 70'({o_i[0][0], o_d[0][0]}), 70'b11);
    stop_all();
    @(negedge clk); #2 rst_n = 1'b1;
    tick(); start_i(100, 32'h1000, 1'b0, 32'h0); start_d(100, 32'h2000, 1'b1, 32'h0); smp();
    tick(); smp(); check("t6_d_after_rst", 70'(o_mem[0][69:38]), 70'h2000);
    tick(); stop_all(); smp(); tick(); smp();

    // Randomized traffic; the reference model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (i_left == 0 && $urandom_range(3) == 0) begin
        start_i($urandom_range(6, 1), $urandom & 32'hFFFC, 1'($urandom_range(1)), $urandom);
        i_be = 4'($urandom);
      end
      if (d_left == 0 && $urandom_range(3) == 0) begin
        start_d($urandom_range(6, 1), $urandom & 32'hFFFC, 1'($urandom_range(1)), $urandom);
        d_be = 4'($urandom);
      end
      mem_busy = ($urandom_range(2) == 0);
      smp();
    end
    tick(); stop_all(); smp(); tick(); smp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
